// File: rtl/zbus_pkg.sv
// zbus_pkg: shared definitions for the ZX bus initiator.
//   - FSM state codes (plain localparam constants for legacy tools)
//   - bus cycle type encoding (memory, I/O, interrupt acknowledge)
//   - number of mandatory TW states per cycle type and a lookup helper
package zbus_pkg;

   localparam logic [2:0] ST_RSTW = 3'd0;
   localparam logic [2:0] ST_IDLE = 3'd1;
   localparam logic [2:0] ST_T1   = 3'd2;
   localparam logic [2:0] ST_T2   = 3'd3;
   localparam logic [2:0] ST_TW   = 3'd4;
   localparam logic [2:0] ST_T3   = 3'd5;

   typedef enum logic [1:0] {
      CYC_MEM  = 2'd0,
      CYC_IO   = 2'd1,
      CYC_INTA = 2'd2
   } cycle_t;

   localparam logic [1:0] TW_MAND_MEM  = 2'd0;
   localparam logic [1:0] TW_MAND_IO   = 2'd1;
   localparam logic [1:0] TW_MAND_INTA = 2'd2;

   // Wait states the initiator inserts on its own, regardless of /WAIT.
   function automatic logic [1:0] mand_tw(input cycle_t cyc);
      case (cyc)
         CYC_IO:   return TW_MAND_IO;
         CYC_INTA: return TW_MAND_INTA;
         default:  return TW_MAND_MEM;
      endcase
   endfunction

endpackage

// File: rtl/zbus_tstate_timer.sv
// zbus_tstate_timer: T-state timing for the ZX bus initiator.
//   fclk, rst  : clock and asynchronous active-high reset
//   run        : a bus cycle is in progress (T1/T2/TW/T3)
//   wait_clr   : clear the extra-wait counter (new request accepted)
//   wait_inc   : one more extra (non-mandatory) TW is being entered
//   t_last     : current fclk is the last one of the current T-state
//   wait_full  : WAIT_MAX extra TW states have already been inserted
module zbus_tstate_timer #(
   parameter int TDIV     = 4,
   parameter int WAIT_MAX = 64
) (
   input  logic fclk,
   input  logic rst,
   input  logic run,
   input  logic wait_clr,
   input  logic wait_inc,
   output logic t_last,
   output logic wait_full
);

   localparam int TCW = (TDIV > 1) ? $clog2(TDIV) : 1;
   localparam int WCW = $clog2(WAIT_MAX + 1);
   localparam logic [TCW-1:0] TLAST = TCW'(TDIV - 1);
   localparam logic [WCW-1:0] WFULL = WCW'(WAIT_MAX);

   logic [TCW-1:0] tcnt;
   logic [WCW-1:0] wcnt;

   // Tcnt sits at 0 while idle so the first fclk after acceptance is Tcnt=0 of T1.
   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         tcnt <= '0;
      end else if (!run || (tcnt == TLAST)) begin
         tcnt <= '0;
      end else begin
         tcnt <= tcnt + TCW'(1);
      end
   end

   // Counts only the TW states requested through /WAIT, saturating at WAIT_MAX.
   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         wcnt <= '0;
      end else if (wait_clr) begin
         wcnt <= '0;
      end else if (wait_inc && !wait_full) begin
         wcnt <= wcnt + WCW'(1);
      end
   end

   assign t_last    = run && (tcnt == TLAST);
   assign wait_full = (wcnt == WFULL);

endmodule

// File: rtl/zbus_initiator.sv
// zbus_initiator: host end of the ZX bus; runs one memory or I/O cycle per request.
//   fclk, rst          : system clock, asynchronous active-high reset
//   req_*              : request handshake (valid/ready), address, write data, rnw, io
//   rsp_*              : one-fclk completion pulse with read data, IORQGE and timeout flags
//   za, zd_out, zd_oe  : address bus and driven data bus
//   zd_in              : data bus as seen from the devices
//   zmreq_n .. zwr_n   : active-low bus strobes
//   zwait_n, ziorqge   : device wait request and I/O claim
//   zint_n/int_pending : device interrupt and its synchronised, inverted copy
//   zrst_n             : bus reset, held low RST_HOLD fclk after rst is released
// Optional: define ZBUS_INITIATOR_INTACK_EN to add req_inta / zm1_n and the
// interrupt-acknowledge cycle.
module zbus_initiator
   import zbus_pkg::*;
#(
   parameter int TDIV     = 4,
   parameter int WAIT_MAX = 64,
   parameter int RST_HOLD = 16
) (
   input  logic        fclk,
   input  logic        rst,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic [15:0] req_addr,
   input  logic [7:0]  req_wdata,
   input  logic        req_rnw,
   input  logic        req_io,
   output logic        rsp_valid,
   output logic [7:0]  rsp_rdata,
   output logic        rsp_iorqge,
   output logic        rsp_timeout,
   output logic [15:0] za,
   output logic [7:0]  zd_out,
   output logic        zd_oe,
   input  logic [7:0]  zd_in,
   output logic        zmreq_n,
   output logic        ziorq_n,
   output logic        zrd_n,
   output logic        zwr_n,
   input  logic        zwait_n,
   input  logic        ziorqge,
   input  logic        zint_n,
`ifdef ZBUS_INITIATOR_INTACK_EN
   input  logic        req_inta,
   output logic        zm1_n,
`endif
   output logic        int_pending,
   output logic        zrst_n
);

   localparam int RCW = $clog2(RST_HOLD + 1);

   logic [2:0]     state;
   cycle_t         cyc;
   logic           rnw;
   logic [1:0]     mand_left;
   logic [1:0]     cyc_mand;
   logic           timed_out;
   logic [RCW-1:0] rst_cnt;
   logic           int_meta;
   logic           accept;
   logic           req_is_inta;
   logic           run;
   logic           t_last;
   logic           wait_full;
   logic           wait_inc;

`ifdef ZBUS_INITIATOR_INTACK_EN
   assign req_is_inta = req_inta;
`else
   assign req_is_inta = 1'b0;
`endif

   assign cyc_mand = mand_tw(cyc);
   assign accept   = (state == ST_IDLE) && req_valid && req_ready;
   assign run      = (state == ST_T1) || (state == ST_T2) || (state == ST_TW) || (state == ST_T3);

   // An extra TW is entered when /WAIT is low at the end of T2 (memory only) or
   // at the end of a TW once the mandatory ones are used up and budget remains.
   assign wait_inc = t_last && !zwait_n &&
                     (((state == ST_T2) && (cyc_mand == 2'd0)) ||
                      ((state == ST_TW) && (mand_left == 2'd0) && !wait_full));

   zbus_tstate_timer #(
      .TDIV     (TDIV),
      .WAIT_MAX (WAIT_MAX)
   ) u_timer (
      .fclk      (fclk),
      .rst       (rst),
      .run       (run),
      .wait_clr  (accept),
      .wait_inc  (wait_inc),
      .t_last    (t_last),
      .wait_full (wait_full)
   );

   // zint_n passes through two flops before it reaches the host.
   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         int_meta    <= 1'b0;
         int_pending <= 1'b0;
      end else begin
         int_meta    <= ~zint_n;
         int_pending <= int_meta;
      end
   end

   // Bus cycle sequencer. All bus outputs are registered and change only on
   // T-state boundaries; rst releases the bus immediately and drops any cycle.
   always_ff @(posedge fclk or posedge rst) begin
      if (rst) begin
         state       <= ST_RSTW;
         rst_cnt     <= '0;
         zrst_n      <= 1'b0;
         req_ready   <= 1'b0;
         cyc         <= CYC_MEM;
         rnw         <= 1'b1;
         mand_left   <= 2'd0;
         timed_out   <= 1'b0;
         za          <= 16'h0000;
         zd_out      <= 8'h00;
         zd_oe       <= 1'b0;
         zmreq_n     <= 1'b1;
         ziorq_n     <= 1'b1;
         zrd_n       <= 1'b1;
         zwr_n       <= 1'b1;
         rsp_valid   <= 1'b0;
         rsp_rdata   <= 8'h00;
         rsp_iorqge  <= 1'b0;
         rsp_timeout <= 1'b0;
`ifdef ZBUS_INITIATOR_INTACK_EN
         zm1_n       <= 1'b1;
`endif
      end else begin
         rsp_valid <= 1'b0;
         case (state)
            ST_RSTW: begin
               if (rst_cnt == RCW'(RST_HOLD - 1)) begin
                  zrst_n    <= 1'b1;
                  req_ready <= 1'b1;
                  state     <= ST_IDLE;
               end else begin
                  rst_cnt <= rst_cnt + RCW'(1);
               end
            end
            ST_IDLE: begin
               if (accept) begin
                  req_ready <= 1'b0;
                  state     <= ST_T1;
                  za        <= req_addr;
                  rnw       <= req_rnw || req_is_inta;
                  mand_left <= 2'd0;
                  timed_out <= 1'b0;
                  cyc       <= req_is_inta ? CYC_INTA : (req_io ? CYC_IO : CYC_MEM);
                  if (!req_rnw && !req_is_inta) begin
                     zd_out <= req_wdata;
                     zd_oe  <= 1'b1;
                  end
`ifdef ZBUS_INITIATOR_INTACK_EN
                  zm1_n <= ~req_inta;
`endif
               end
            end
            ST_T1: begin
               // INTA uses IORQ alone; the vector is read without RD.
               if (t_last) begin
                  state <= ST_T2;
                  if (cyc == CYC_MEM) begin
                     zmreq_n <= 1'b0;
                  end else begin
                     ziorq_n <= 1'b0;
                  end
                  if (cyc != CYC_INTA) begin
                     if (rnw) begin
                        zrd_n <= 1'b0;
                     end else begin
                        zwr_n <= 1'b0;
                     end
                  end
               end
            end
            ST_T2: begin
               // mand_left holds the mandatory TWs still owed after the one being entered.
               if (t_last) begin
                  if (cyc_mand != 2'd0) begin
                     state     <= ST_TW;
                     mand_left <= cyc_mand - 2'd1;
                  end else if (zwait_n) begin
                     state <= ST_T3;
                  end else begin
                     state <= ST_TW;
                  end
               end
            end
            ST_TW: begin
               if (t_last) begin
                  if (mand_left != 2'd0) begin
                     mand_left <= mand_left - 2'd1;
                  end else if (zwait_n) begin
                     state <= ST_T3;
                  end else if (wait_full) begin
                     state     <= ST_T3;
                     timed_out <= 1'b1;
                  end
               end
            end
            ST_T3: begin
               if (t_last) begin
                  state       <= ST_IDLE;
                  req_ready   <= 1'b1;
                  zmreq_n     <= 1'b1;
                  ziorq_n     <= 1'b1;
                  zrd_n       <= 1'b1;
                  zwr_n       <= 1'b1;
                  zd_oe       <= 1'b0;
                  rsp_valid   <= 1'b1;
                  rsp_rdata   <= rnw ? zd_in : 8'h00;
                  rsp_iorqge  <= ziorqge;
                  rsp_timeout <= timed_out;
`ifdef ZBUS_INITIATOR_INTACK_EN
                  zm1_n <= 1'b1;
`endif
               end
            end
            default: begin
               state     <= ST_IDLE;
               req_ready <= zrst_n;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_zbus_initiator.sv
// tb_zbus_initiator: directed self-checking bench for zbus_initiator
// (default build, TDIV=4, WAIT_MAX=4, RST_HOLD=16).
module tb_zbus_initiator;

   localparam int TDIV     = 4;
   localparam int WAIT_MAX = 4;
   localparam int RST_HOLD = 16;

   logic        fclk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_ready;
   logic [15:0] req_addr;
   logic [7:0]  req_wdata;
   logic        req_rnw;
   logic        req_io;
   logic        rsp_valid;
   logic [7:0]  rsp_rdata;
   logic        rsp_iorqge;
   logic        rsp_timeout;
   logic [15:0] za;
   logic [7:0]  zd_out;
   logic        zd_oe;
   logic [7:0]  zd_in;
   logic        zmreq_n;
   logic        ziorq_n;
   logic        zrd_n;
   logic        zwr_n;
   logic        zwait_n;
   logic        ziorqge;
   logic        zint_n;
   logic        int_pending;
   logic        zrst_n;

   int check_count = 0;
   int pass_count  = 0;

   int          obs_latency;
   int          obs_mreq_lo;
   int          obs_iorq_lo;
   int          obs_rd_lo;
   int          obs_wr_lo;
   int          obs_overlap;
   int          obs_ready_busy;
   logic        obs_oe0;
   logic [7:0]  obs_dout0;
   logic [15:0] obs_za0;
   logic [15:0] obs_za_end;
   logic [3:0]  obs_strobes_end;
   logic        obs_pulse_next;

   int rst_rise;
   int rst_ready;
   int rst_rsp_seen;

   always #5 fclk = ~fclk;

   zbus_initiator #(
      .TDIV     (TDIV),
      .WAIT_MAX (WAIT_MAX),
      .RST_HOLD (RST_HOLD)
   ) dut (
      .fclk        (fclk),
      .rst         (rst),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req_addr    (req_addr),
      .req_wdata   (req_wdata),
      .req_rnw     (req_rnw),
      .req_io      (req_io),
      .rsp_valid   (rsp_valid),
      .rsp_rdata   (rsp_rdata),
      .rsp_iorqge  (rsp_iorqge),
      .rsp_timeout (rsp_timeout),
      .za          (za),
      .zd_out      (zd_out),
      .zd_oe       (zd_oe),
      .zd_in       (zd_in),
      .zmreq_n     (zmreq_n),
      .ziorq_n     (ziorq_n),
      .zrd_n       (zrd_n),
      .zwr_n       (zwr_n),
      .zwait_n     (zwait_n),
      .ziorqge     (ziorqge),
      .zint_n      (zint_n),
      .int_pending (int_pending),
      .zrst_n      (zrst_n)
   );

   // One comparison: counts it and reports a mismatch.
   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      check_count++;
      if (actual === expected) begin
         pass_count++;
      end else begin
         $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
      end
   endtask

   // Issues one request and watches the bus until rsp_valid (bounded).
   // Observation n is taken on the n-th falling edge after the accepting edge,
   // so it shows the state left by rising edge n. zwait_n is held low until
   // observation wait_release, i.e. edges after wait_release see it high.
   task automatic applyStimulus(input logic [15:0] addr, input logic [7:0] wdata,
                                input logic rnw, input logic io, input int wait_release);
      @(negedge fclk);
      checkOutput("readyBeforeReq", {31'd0, req_ready}, 32'd1);
      req_addr  = addr;
      req_wdata = wdata;
      req_rnw   = rnw;
      req_io    = io;
      req_valid = 1'b1;
      zwait_n   = (wait_release <= 0);
      @(posedge fclk);
      #1 req_valid = 1'b0;
      obs_latency     = -1;
      obs_mreq_lo     = 0;
      obs_iorq_lo     = 0;
      obs_rd_lo       = 0;
      obs_wr_lo       = 0;
      obs_overlap     = 0;
      obs_ready_busy  = 0;
      obs_strobes_end = 4'h0;
      obs_za_end      = 16'h0000;
      for (int n = 0; n < 200; n++) begin
         @(negedge fclk);
         if (n == 0) begin
            obs_oe0   = zd_oe;
            obs_dout0 = zd_out;
            obs_za0   = za;
         end
         if (rsp_valid) begin
            obs_latency     = n;
            obs_strobes_end = {zmreq_n, ziorq_n, zrd_n, zwr_n};
            obs_za_end      = za;
            break;
         end
         if (!zmreq_n) obs_mreq_lo++;
         if (!ziorq_n) obs_iorq_lo++;
         if (!zrd_n) obs_rd_lo++;
         if (!zwr_n) obs_wr_lo++;
         if (zd_oe && !zrd_n) obs_overlap++;
         if (req_ready) obs_ready_busy++;
         zwait_n = (n >= wait_release);
      end
      @(negedge fclk);
      obs_pulse_next = rsp_valid;
      zwait_n = 1'b1;
   endtask

   // Counts rising edges after rst release until zrst_n and req_ready rise (bounded).
   task automatic waitBusReset();
      rst_rise     = -1;
      rst_ready    = -1;
      rst_rsp_seen = 0;
      for (int n = 1; n <= 40; n++) begin
         @(posedge fclk);
         #1;
         if (zrst_n && rst_rise < 0) rst_rise = n;
         if (req_ready && rst_ready < 0) rst_ready = n;
         if (rsp_valid) rst_rsp_seen++;
         if (rst_rise > 0 && rst_ready > 0) break;
      end
   endtask

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation did not finish in time");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = 16'h0000;
      req_wdata = 8'h00;
      req_rnw   = 1'b1;
      req_io    = 1'b0;
      zd_in     = 8'h00;
      zwait_n   = 1'b1;
      ziorqge   = 1'b0;
      zint_n    = 1'b1;

      // Reset state
      repeat (3) @(posedge fclk);
      #1;
      checkOutput("rstStrobes", {28'd0, zmreq_n, ziorq_n, zrd_n, zwr_n}, 32'hF);
      checkOutput("rstBus", {7'd0, zd_oe, za, zd_out}, 32'h0);
      checkOutput("rstRsp", {21'd0, req_ready, rsp_valid, rsp_rdata, rsp_iorqge, rsp_timeout}, 32'h0);
      checkOutput("rstZrstInt", {30'd0, zrst_n, int_pending}, 32'h0);

      // zrst_n hold after release
      @(negedge fclk);
      rst = 1'b0;
      waitBusReset();
      checkOutput("zrstRiseAt", rst_rise, 32'd16);
      checkOutput("readyRiseAt", rst_ready, 32'd16);
      checkOutput("postRstStrobes", {28'd0, zmreq_n, ziorq_n, zrd_n, zwr_n}, 32'hF);

      // Interrupt synchroniser: two flops
      @(negedge fclk);
      zint_n = 1'b0;
      @(posedge fclk);
      #1 checkOutput("intAfter1", {31'd0, int_pending}, 32'd0);
      @(posedge fclk);
      #1 checkOutput("intAfter2", {31'd0, int_pending}, 32'd1);
      @(negedge fclk);
      zint_n = 1'b1;
      repeat (2) @(posedge fclk);
      #1 checkOutput("intCleared", {31'd0, int_pending}, 32'd0);

      // Memory write 0x5B00 <- 0xA5, no waits
      ziorqge = 1'b0;
      zd_in   = 8'hFF;
      applyStimulus(16'h5B00, 8'hA5, 1'b0, 1'b0, 0);
      checkOutput("mwLatency", obs_latency, 32'd12);
      checkOutput("mwMreqLow", obs_mreq_lo, 32'd8);
      checkOutput("mwWrLow", obs_wr_lo, 32'd8);
      checkOutput("mwRdIorqLow", obs_rd_lo + obs_iorq_lo, 32'd0);
      checkOutput("mwT1Drive", {7'd0, obs_oe0, obs_za0, obs_dout0}, {7'd0, 1'b1, 16'h5B00, 8'hA5});
      checkOutput("mwEndStrobes", {28'd0, obs_strobes_end}, 32'hF);
      checkOutput("mwOeOff", {31'd0, zd_oe}, 32'd0);
      checkOutput("mwPulse", {31'd0, obs_pulse_next}, 32'd0);
      checkOutput("mwRsp", {22'd0, rsp_rdata, rsp_iorqge, rsp_timeout}, 32'h0);
      checkOutput("mwReadyBusy", obs_ready_busy, 32'd0);

      // I/O read 0x00AB, device returns 0x3C and claims the cycle
      zd_in   = 8'h3C;
      ziorqge = 1'b1;
      applyStimulus(16'h00AB, 8'h00, 1'b1, 1'b1, 0);
      checkOutput("ioLatency", obs_latency, 32'd16);
      checkOutput("ioIorqLow", obs_iorq_lo, 32'd12);
      checkOutput("ioRdLow", obs_rd_lo, 32'd12);
      checkOutput("ioMreqWrLow", obs_mreq_lo + obs_wr_lo, 32'd0);
      checkOutput("ioNoDrive", {31'd0, obs_oe0}, 32'd0);
      checkOutput("ioAddrHeld", {obs_za0, obs_za_end}, {16'h00AB, 16'h00AB});
      checkOutput("ioRsp", {22'd0, rsp_rdata, rsp_iorqge, rsp_timeout}, {22'd0, 8'h3C, 1'b1, 1'b0});
      ziorqge = 1'b0;

      // Memory read stretched by three TW states
      zd_in = 8'h77;
      applyStimulus(16'h8000, 8'h00, 1'b1, 1'b0, 16);
      checkOutput("wsLatency", obs_latency, 32'd24);
      checkOutput("wsMreqLow", obs_mreq_lo, 32'd20);
      checkOutput("wsOverlap", obs_overlap, 32'd0);
      checkOutput("wsRsp", {22'd0, rsp_rdata, rsp_iorqge, rsp_timeout}, {22'd0, 8'h77, 1'b0, 1'b0});

      // /WAIT stuck low: abort after WAIT_MAX extra TWs
      zd_in = 8'h11;
      applyStimulus(16'hC000, 8'h00, 1'b1, 1'b0, 1000);
      checkOutput("toLatency", obs_latency, 32'd28);
      checkOutput("toTimeout", {31'd0, rsp_timeout}, 32'd1);
      checkOutput("toStrobes", {28'd0, obs_strobes_end}, 32'hF);
      checkOutput("toMreqLow", obs_mreq_lo, 32'd24);

      // Following plain read clears the timeout flag
      zd_in = 8'h5A;
      applyStimulus(16'h1234, 8'h00, 1'b1, 1'b0, 0);
      checkOutput("recLatency", obs_latency, 32'd12);
      checkOutput("recRsp", {22'd0, rsp_rdata, rsp_iorqge, rsp_timeout}, {22'd0, 8'h5A, 1'b0, 1'b0});
      checkOutput("rspHold", {31'd0, rsp_timeout}, 32'd0);

      // Reset during T2 of an I/O write
      @(negedge fclk);
      req_addr  = 16'h00FE;
      req_wdata = 8'h42;
      req_rnw   = 1'b0;
      req_io    = 1'b1;
      req_valid = 1'b1;
      @(posedge fclk);
      #1 req_valid = 1'b0;
      repeat (6) @(negedge fclk);
      checkOutput("midBefore", {29'd0, ziorq_n, zwr_n, zd_oe}, 32'b001);
      #2 rst = 1'b1;
      #1;
      checkOutput("midStrobes", {28'd0, zmreq_n, ziorq_n, zrd_n, zwr_n}, 32'hF);
      checkOutput("midOeZrst", {30'd0, zd_oe, zrst_n}, 32'd0);
      repeat (2) @(posedge fclk);
      @(negedge fclk);
      rst = 1'b0;
      waitBusReset();
      checkOutput("midZrstRise", rst_rise, 32'd16);
      checkOutput("midNoRsp", rst_rsp_seen, 32'd0);

      $display("%0d/%0d checks passed", pass_count, check_count);
      $finish;
   end

endmodule

// File: doc/zbus_initiator.md
Name: zbus_initiator

Overview:
- Z80-style ZX bus cycle generator: the host/CPU end of the ZX bus our card sits on.
- Turns one-at-a-time requests into memory or I/O read/write cycles with correct T-state sequencing, /WAIT stretching and IORQGE sampling.
- Used as the bus-master model in the card's system bench and as the host side of the FPGA bridge that exercises the W5300/SL811 windows.

Parameters:
- TDIV, 4: fclk cycles per T-state (>=2).
- WAIT_MAX, 64: maximum extra TW states before timeout abort.
- RST_HOLD, 16: fclk cycles zrst_n is held low after rst deasserts.

Ports:
- fclk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept (IDLE only)
- req_addr  in  16  bus address
- req_wdata  in  8  write data
- req_rnw  in  1  1=read, 0=write
- req_io  in  1  1=I/O cycle, 0=memory cycle
- rsp_valid  out  1  one-fclk completion pulse
- rsp_rdata  out  8  read data (valid with rsp_valid)
- rsp_iorqge  out  1  ziorqge sampled in the cycle
- rsp_timeout  out  1  cycle aborted on WAIT_MAX
- za  out  16  address bus
- zd_out  out  8  data to bus
- zd_oe  out  1  data bus drive enable
- zd_in  in  8  data from bus
- zmreq_n, ziorq_n, zrd_n, zwr_n  out  1 each  bus strobes
- zwait_n  in  1  wait request from devices
- ziorqge  in  1  device I/O claim
- zint_n  in  1  device interrupt
- int_pending  out  1  zint_n synchronised and inverted
- zrst_n  out  1  bus reset

Behaviour:
- Reset (async, immediate): strobes 1, zd_oe 0, za 0, zd_out 0, req_ready 0, rsp_* 0, int_pending 0, zrst_n 0.
- After rst falls: zrst_n stays 0 for RST_HOLD fclk, then 1. req_ready=1 only when zrst_n=1 and state IDLE.
- Tcnt counts 0..TDIV-1 within each T-state.
- FSM states: RSTW, IDLE, T1, T2, TW, T3.
- IDLE: accept on req_valid&&req_ready; latch all req_* fields; go to T1, Tcnt=0.
- T1: za=latched addr from first T1 cycle. For writes, zd_out=wdata and zd_oe=1 from first T1 cycle.
- T2 entry: assert zmreq_n (mem) or ziorq_n (io), together with zrd_n or zwr_n.
- T2 exit:
  - I/O: always one mandatory TW after T2.
  - Memory: sample zwait_n on the last fclk of T2; if 0, go to TW, else go to T3.
- TW: on its last fclk sample zwait_n; 0 means another TW, 1 means T3.
  - Mandatory I/O TW does not count against WAIT_MAX; extra TWs do.
  - Exceeding WAIT_MAX ends the cycle: go to T3 with rsp_timeout=1.
- T3:
  - On the last fclk, capture zd_in into rsp_rdata (reads; writes leave it 0) and ziorqge into rsp_iorqge.
  - Next edge: strobes deasserted, zd_oe=0, rsp_valid=1 for one fclk, state IDLE. za holds its value.
- Latency, accept to rsp_valid with no waits: mem 3*TDIV, io 4*TDIV, plus TDIV per extra TW.
- Back-to-back: a new request is accepted no earlier than the rsp_valid cycle+1, so strobes are high for at least 1 fclk between cycles.
- zd_oe is never 1 while zrd_n=0.
- rsp_* fields hold until the next rsp_valid.
- int_pending: zint_n through a 2-flop synchroniser.
- Reset mid-cycle: bus released in the same instant, no rsp_valid, request lost.

Optional Feature:
- Macro ZBUS_INITIATOR_INTACK_EN.
- With the macro:
  - Adds port zm1_n (out, 1, reset 1) and input req_inta.
  - A request with req_inta=1 runs an interrupt-acknowledge cycle: zm1_n=0 from T1; ziorq_n=0 (no zrd_n) from T2; two mandatory TWs; vector captured at end of T3 into rsp_rdata.
  - zm1_n is also asserted in T1–T2 of every memory read with req_io=0... no: zm1_n is asserted only for INTA.
- Without the macro: no zm1_n and no req_inta ports; only mem/io cycles exist.

Decomposition:
- Package zbus_pkg:
  - state enum (RSTW, IDLE, T1, T2, TW, T3);
  - cycle-type encoding (MEM, IO, INTA);
  - localparams for mandatory TW counts (MEM 0, IO 1, INTA 2).
- One sub-module: zbus_tstate_timer, holding the Tcnt divider, the last-fclk-of-T-state strobe and the WAIT_MAX counter.

Test Plan:
- Reset: rst 1→0, TDIV=4 → zrst_n rises exactly 16 fclk later; req_ready rises the same cycle; all strobes 1.
- Mem write: addr 0x5B00, data 0xA5, zwait_n=1 → zmreq_n/zwr_n low for 2*TDIV fclk; zd_oe=1 from T1; rsp_valid at 12 fclk.
- IO read:
  - Stimulus: addr 0x00AB, device drives 0x3C, ziorqge=1.
  - Response: ziorq_n/zrd_n low for 3*TDIV; rsp_rdata=0x3C, rsp_iorqge=1; rsp_valid at 16 fclk.
- Wait stretch: mem read with zwait_n=0 for 3 TW samples → 3 extra TDIV; rsp_valid at 24 fclk; rsp_timeout=0.
- Timeout: zwait_n stuck 0, WAIT_MAX=4 → rsp_timeout=1; rsp_valid at 3*TDIV+4*TDIV; strobes released.
- Mid-cycle reset: rst pulsed during T2 of an IO write → strobes high and zd_oe=0 the same instant; no rsp_valid; zrst_n low for 16 fclk after release.
